// File: rtl/reaction_timer_ctrl_pkg.sv
// reaction_pkg: shared definitions for the reaction-timer game.
//   - trial state encoding (3 bits)
//   - feedback tap mask for the 16-bit Fibonacci LFSR
//   - default timing limits, also used by the display block
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    STIM    = 3'd2,
    RESULT  = 3'd3,
    TIMEOUT = 3'd4,
    FAULT   = 3'd5
  } state_t;

  // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int DEF_MAX_MS       = 9999;
  localparam int DEF_MIN_DELAY_MS = 1000;

endpackage

// File: rtl/reaction_timer_ctrl_if.sv
// reaction_timer_if: game-side signals of the reaction-timer controller.
//   master: drives tick_1kHz, start_btn, react_btn; observes the results
//   slave : the controller; consumes tick/buttons, drives led_stim,
//           ms_count, result_valid, false_start, timeout, busy
interface reaction_timer_if #(
  parameter int CNT_W = 14
);
  logic             tick_1kHz;
  logic             start_btn;
  logic             react_btn;
  logic             led_stim;
  logic [CNT_W-1:0] ms_count;
  logic             result_valid;
  logic             false_start;
  logic             timeout;
  logic             busy;

  modport master (
    output tick_1kHz, start_btn, react_btn,
    input  led_stim, ms_count, result_valid, false_start, timeout, busy
  );

  modport slave (
    input  tick_1kHz, start_btn, react_btn,
    output led_stim, ms_count, result_valid, false_start, timeout, busy
  );
endinterface

// File: rtl/reaction_timer_ctrl_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, free running.
//   clk   : clock, advances every cycle
//   reset : synchronous active-high, loads SEED
//   state : current register value (never zero for a non-zero SEED)
module lfsr16
  import reaction_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (reset) state <= SEED;
    else       state <= {state[14:0], ^(state & LFSR_TAPS)};
  end

endmodule

// File: rtl/reaction_timer_ctrl.sv
// reaction_timer_ctrl: trial sequencer for the reaction-timer game.
// Waits a pseudo-random 1000..5095 ms after a start press, lights the
// stimulus LED, counts ms until the reaction press and holds the result.
//   clk_50MHz : system clock
//   reset     : synchronous active-high
//   rt        : reaction_timer_if.slave (tick, buttons, LED, count, flags)
// Optional build macro: REACTION_FALSE_START_EN -- a react press while
// armed ends the trial in FAULT; otherwise such presses are ignored.
//
// state   | meaning
// IDLE    | after reset, waiting for first start press
// ARM     | random delay running, LED off
// STIM    | LED on, counting ms until react press
// RESULT  | reaction time held
// TIMEOUT | no reaction within MAX_MS, MAX_MS held
// FAULT   | react pressed before the stimulus
module reaction_timer_ctrl
  import reaction_pkg::*;
#(
  parameter int          MIN_DELAY_MS = DEF_MIN_DELAY_MS,
  parameter int          MAX_MS       = DEF_MAX_MS,
  parameter int          CNT_W        = 14,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input logic            clk_50MHz,
  input logic            reset,
  reaction_timer_if.slave rt
);

`ifdef REACTION_FALSE_START_EN
  localparam bit FALSE_START_EN = 1'b1;
`else
  localparam bit FALSE_START_EN = 1'b0;
`endif

  state_t           state, state_nxt;
  logic [CNT_W-1:0] delay_cnt, delay_nxt;
  logic [CNT_W-1:0] ms_cnt, ms_nxt;
  logic [15:0]      lfsr;
  logic             start_q, react_q;
  logic             start_edge, react_edge;
  logic             led_stim_r, busy_r, result_valid_r, timeout_r, false_start_r;
  logic             unused_lfsr;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk_50MHz),
    .reset (reset),
    .state (lfsr)
  );

  // only the low 12 bits feed the delay
  assign unused_lfsr = ^lfsr[15:12];

  assign start_edge = rt.start_btn & ~start_q;
  assign react_edge = rt.react_btn & ~react_q;

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state          <= IDLE;
      delay_cnt      <= '0;
      ms_cnt         <= '0;
      start_q        <= 1'b0;
      react_q        <= 1'b0;
      led_stim_r     <= 1'b0;
      busy_r         <= 1'b0;
      result_valid_r <= 1'b0;
      timeout_r      <= 1'b0;
      false_start_r  <= 1'b0;
    end else begin
      state          <= state_nxt;
      delay_cnt      <= delay_nxt;
      ms_cnt         <= ms_nxt;
      start_q        <= rt.start_btn;
      react_q        <= rt.react_btn;
      // flags decoded from the next state so they align with the state register
      led_stim_r     <= (state_nxt == STIM);
      busy_r         <= (state_nxt == ARM) || (state_nxt == STIM);
      result_valid_r <= (state_nxt == RESULT);
      timeout_r      <= (state_nxt == TIMEOUT);
      false_start_r  <= FALSE_START_EN && (state_nxt == FAULT);
    end
  end

  always_comb begin
    state_nxt = state;
    delay_nxt = delay_cnt;
    ms_nxt    = ms_cnt;
    unique case (state)
      IDLE, RESULT, TIMEOUT, FAULT: begin
        if (start_edge) begin
          state_nxt = ARM;
          delay_nxt = CNT_W'(MIN_DELAY_MS) + CNT_W'(lfsr[11:0]);
          ms_nxt    = '0;
        end
      end
      ARM: begin
        // a react press beats a simultaneous delay expiry
        if (FALSE_START_EN && react_edge) begin
          state_nxt = FAULT;
          ms_nxt    = '0;
        end else if (rt.tick_1kHz) begin
          if (delay_cnt == CNT_W'(1)) begin
            state_nxt = STIM;
            ms_nxt    = '0;
          end else begin
            delay_nxt = delay_cnt - CNT_W'(1);
          end
        end
      end
      STIM: begin
        // react wins over a same-cycle tick: only ticks before the press count
        if (react_edge) begin
          state_nxt = RESULT;
        end else if (rt.tick_1kHz) begin
          if (ms_cnt == CNT_W'(MAX_MS - 1)) begin
            state_nxt = TIMEOUT;
            ms_nxt    = CNT_W'(MAX_MS);
          end else begin
            ms_nxt = ms_cnt + CNT_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rt.led_stim     = led_stim_r;
  assign rt.busy         = busy_r;
  assign rt.result_valid = result_valid_r;
  assign rt.timeout      = timeout_r;
  assign rt.false_start  = false_start_r;
  assign rt.ms_count     = ms_cnt;

endmodule

// File: tb/tb_reaction_timer_ctrl.sv
// tb_reaction_timer_ctrl: self-checking bench for reaction_timer_ctrl.
// Expected trial outcomes are queued when the deciding stimulus is driven
// and compared when a result/timeout/false-start flag rises.
// Honours REACTION_FALSE_START_EN the same way as the design build.
module tb_reaction_timer_ctrl;
  import reaction_pkg::*;

  localparam int          CNT_W = 14;
  localparam int          MIN_D = 1000;
  localparam int          MAXMS = 9999;
  localparam logic [15:0] SEED  = 16'hACE1;

  localparam logic [2:0] K_RES = 3'b001;
  localparam logic [2:0] K_TO  = 3'b010;
  localparam logic [2:0] K_FS  = 3'b100;

  logic clk_50MHz = 1'b0;
  logic reset     = 1'b1;
  always #10 clk_50MHz = ~clk_50MHz;

  reaction_timer_if #(.CNT_W(CNT_W)) rt_if ();

  reaction_timer_ctrl #(
    .MIN_DELAY_MS (MIN_D),
    .MAX_MS       (MAXMS),
    .CNT_W        (CNT_W),
    .LFSR_SEED    (SEED)
  ) dut (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .rt        (rt_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // reference LFSR, written from the polynomial
  logic [15:0] m_lfsr;
  always @(posedge clk_50MHz) begin
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  typedef struct {
    logic [2:0] kind;
    int         ms;
  } exp_t;
  exp_t sb_q[$];

  logic [2:0] flags_now;
  logic [2:0] flags_q = 3'b000;
  assign flags_now = {rt_if.false_start, rt_if.timeout, rt_if.result_valid};

  always @(negedge clk_50MHz) begin
    if (flags_now != 3'b000 && flags_q == 3'b000) begin
      if (sb_q.size() == 0) begin
        check_val("sb_unexpected", 32'(flags_now), 32'd0);
      end else begin
        check_val("sb_kind", 32'(flags_now), 32'(sb_q[0].kind));
        check_val("sb_ms", 32'(rt_if.ms_count), 32'(sb_q[0].ms));
        sb_q.delete(0);
      end
    end
    flags_q <= flags_now;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_50MHz);
  endtask

  task automatic ticks(input int n);
    rt_if.tick_1kHz = 1'b1;
    cyc(n);
    rt_if.tick_1kHz = 1'b0;
  endtask

  task automatic press_start(output int d);
    d = MIN_D + int'(m_lfsr[11:0]);
    rt_if.start_btn = 1'b1;
    cyc(1);
    rt_if.start_btn = 1'b0;
    cyc(1);
  endtask

  task automatic press_react();
    rt_if.react_btn = 1'b1;
    cyc(1);
    rt_if.react_btn = 1'b0;
  endtask

  task automatic push_exp(input logic [2:0] kind, input int ms);
    exp_t e;
    e.kind = kind;
    e.ms   = ms;
    sb_q.push_back(e);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_outs"},
              32'({rt_if.led_stim, rt_if.busy, rt_if.result_valid, rt_if.timeout, rt_if.false_start}),
              32'd0);
    check_val({tag, "_ms"}, 32'(rt_if.ms_count), 32'd0);
  endtask

  initial begin
    int d;
    rt_if.tick_1kHz = 1'b0;
    rt_if.start_btn = 1'b0;
    rt_if.react_btn = 1'b0;

    // reset
    cyc(3);
    check_idle_outputs("reset");
    reset = 1'b0;
    cyc(1);
    check_idle_outputs("idle");

    // trial 1: normal reaction of 250 ms
    press_start(d);
    check_val("t1_busy", 32'(rt_if.busy), 32'd1);
    ticks(d - 1);
    check_val("t1_led_pre", 32'(rt_if.led_stim), 32'd0);
    check_val("t1_busy_pre", 32'(rt_if.busy), 32'd1);
    ticks(1);
    check_val("t1_led_on", 32'(rt_if.led_stim), 32'd1);
    check_val("t1_ms0", 32'(rt_if.ms_count), 32'd0);
    ticks(250);
    push_exp(K_RES, 250);
    press_react();
    check_val("t1_rv", 32'(rt_if.result_valid), 32'd1);
    check_val("t1_led_off", 32'(rt_if.led_stim), 32'd0);
    ticks(100);
    check_val("t1_ms_hold", 32'(rt_if.ms_count), 32'd250);

    // trial 2: react in the same cycle as tick 251
    press_start(d);
    check_val("t2_rv_clr", 32'(rt_if.result_valid), 32'd0);
    check_val("t2_busy", 32'(rt_if.busy), 32'd1);
    ticks(d);
    check_val("t2_led_on", 32'(rt_if.led_stim), 32'd1);
    ticks(250);
    push_exp(K_RES, 250);
    rt_if.react_btn = 1'b1;
    rt_if.tick_1kHz = 1'b1;
    cyc(1);
    rt_if.react_btn = 1'b0;
    rt_if.tick_1kHz = 1'b0;
    check_val("t2_ms", 32'(rt_if.ms_count), 32'd250);

    // trial 3: timeout
    press_start(d);
    ticks(d);
    push_exp(K_TO, MAXMS);
    ticks(MAXMS - 1);
    check_val("t3_ms_pre", 32'(rt_if.ms_count), 32'(MAXMS - 1));
    check_val("t3_led_pre", 32'(rt_if.led_stim), 32'd1);
    ticks(1);
    check_val("t3_to", 32'(rt_if.timeout), 32'd1);
    check_val("t3_ms_max", 32'(rt_if.ms_count), 32'(MAXMS));
    check_val("t3_busy", 32'(rt_if.busy), 32'd0);
    ticks(5);
    check_val("t3_ms_sat", 32'(rt_if.ms_count), 32'(MAXMS));
    press_start(d);
    check_val("t4_to_clr", 32'(rt_if.timeout), 32'd0);
    check_val("t4_busy", 32'(rt_if.busy), 32'd1);

    // trial 4: react 10 ticks into ARM
    ticks(10);
`ifdef REACTION_FALSE_START_EN
    push_exp(K_FS, 0);
    press_react();
    check_val("t4_fs", 32'(rt_if.false_start), 32'd1);
    check_val("t4_ms", 32'(rt_if.ms_count), 32'd0);
    check_val("t4_busy_off", 32'(rt_if.busy), 32'd0);
    ticks(d);
    check_val("t4_led_never", 32'(rt_if.led_stim), 32'd0);
    check_val("t4_fs_hold", 32'(rt_if.false_start), 32'd1);
`else
    press_react();
    check_val("t4_fs", 32'(rt_if.false_start), 32'd0);
    check_val("t4_busy_arm", 32'(rt_if.busy), 32'd1);
    check_val("t4_led_arm", 32'(rt_if.led_stim), 32'd0);
    ticks(d - 10);
    check_val("t4_led_on", 32'(rt_if.led_stim), 32'd1);
    ticks(3);
    push_exp(K_RES, 3);
    press_react();
    check_val("t4_rv", 32'(rt_if.result_valid), 32'd1);
`endif

    // trial 5: reset mid-STIM at ms_count = 40
    press_start(d);
    ticks(d);
    ticks(40);
    check_val("t5_ms40", 32'(rt_if.ms_count), 32'd40);
    reset = 1'b1;
    cyc(1);
    check_idle_outputs("t5_reset");
    check_val("t5_lfsr", 32'(dut.u_lfsr.state), 32'(SEED));
    reset = 1'b0;

    // start held for 5 cycles right after reset: one trial, delay from the seed
    rt_if.start_btn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check_val("t6_busy_hold", 32'(rt_if.busy), 32'd1);
    end
    rt_if.start_btn = 1'b0;
    ticks(MIN_D + 32'h0CE1 - 1);
    check_val("t6_led_pre", 32'(rt_if.led_stim), 32'd0);
    ticks(1);
    check_val("t6_led_on", 32'(rt_if.led_stim), 32'd1);
    ticks(7);
    push_exp(K_RES, 7);
    press_react();
    check_val("t6_rv", 32'(rt_if.result_valid), 32'd1);
    cyc(5);
    check_val("t6_no_retrig", 32'(rt_if.busy), 32'd0);
    check_val("t6_rv_hold", 32'(rt_if.result_valid), 32'd1);

    cyc(2);
    check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
